case_5_mac_accum: RTL and testbench

//   Downstream consumer of the case_5 signed multiplier stage (6s x 4s -> 6-bit product).

---
 rtl/case_5_mac_accum_if.sv | 42 ++++
 rtl/case_5_mac_accum.sv | 115 +++++++++++
 tb/tb_case_5_mac_accum.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/case_5_mac_accum_if.sv
// ---------------------------------------------------------------------------
// case_5_mac_accum_if
//   Bundles the control handshake and both data streams of case_5_mac_accum.
//   Clock and reset stay plain ports on the block.
//
//   Control : ap_start, len  -> block ; ap_done, ap_idle, ap_ready <- block
//   Input   : in_valid, in_a, in_b -> block ; in_ready <- block
//   Output  : out_ready -> block ; out_valid, out_data, out_sat <- block
//
//   master : the side that issues transactions and supplies operands
//   slave  : the accumulator block itself
// ---------------------------------------------------------------------------
interface case_5_mac_accum_if #(
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 4,
  parameter int ACC_WIDTH  = 12,
  parameter int LEN_WIDTH  = 8
);
  logic                         ap_start;
  logic                         ap_done;
  logic                         ap_idle;
  logic                         ap_ready;
  logic        [LEN_WIDTH-1:0]  len;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] in_a;
  logic signed [DIN1_WIDTH-1:0] in_b;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  out_data;
  logic                         out_sat;

  modport master (
    output ap_start, len, in_valid, in_a, in_b, out_ready,
    input  ap_done, ap_idle, ap_ready, in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  ap_start, len, in_valid, in_a, in_b, out_ready,
    output ap_done, ap_idle, ap_ready, in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/case_5_mac_accum.sv
// ---------------------------------------------------------------------------
// case_5_mac_accum
//   Accepts a burst of len signed operand pairs, multiplies each pair,
//   truncates the product to PROD_WIDTH bits and sums the products into a
//   saturating signed accumulator. The sum is offered on a valid/ready
//   output; out_sat flags that at least one add clamped.
//
//   ap_clk   : clock, rising edge
//   ap_rst_n : synchronous active-low reset
//   bus      : case_5_mac_accum_if.slave (control handshake, input stream,
//              output stream)
// ---------------------------------------------------------------------------
module case_5_mac_accum #(
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 4,
  parameter int PROD_WIDTH = 6,
  parameter int ACC_WIDTH  = 12,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  case_5_mac_accum_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                       state_q, state_d;
  logic        [LEN_WIDTH-1:0]  len_q;
  logic        [LEN_WIDTH-1:0]  count_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         sat_q;

  logic                         beat;
  logic                         last_beat;
  logic signed [PROD_WIDTH-1:0] a_ext, b_ext, prod;
  logic signed [ACC_WIDTH:0]    sum;
  logic                         ovf;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  assign beat      = bus.in_valid && (state_q == S_RUN);
  assign last_beat = (count_q == len_q - LEN_WIDTH'(1));

  // Only the low PROD_WIDTH bits of a*b are kept, and those depend only on
  // the low PROD_WIDTH bits of the sign-extended operands, so the multiply
  // is done directly at PROD_WIDTH.
  assign a_ext = PROD_WIDTH'(bus.in_a);
  assign b_ext = PROD_WIDTH'(bus.in_b);
  assign prod  = a_ext * b_ext;

  // One guard bit: the sum overflowed iff the two top bits disagree, and the
  // guard bit then gives the direction of the overflow.
  assign sum = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
  assign ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

  always_comb begin
    if (!ovf)                 acc_next = sum[ACC_WIDTH-1:0];
    else if (sum[ACC_WIDTH])  acc_next = ACC_MIN;
    else                      acc_next = ACC_MAX;
  end

  // NOTE: next state takes a default before the case so that no path leaves
  // it unassigned; otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.ap_start) state_d = (bus.len == '0) ? S_OUT : S_RUN;
      S_RUN:  if (beat && last_beat) state_d = S_OUT;
      S_OUT:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.ap_start) begin
        len_q   <= bus.len;
        count_q <= '0;
        acc_q   <= '0;
        sat_q   <= 1'b0;
      end else if (beat) begin
        count_q <= count_q + LEN_WIDTH'(1);
        acc_q   <= acc_next;
        sat_q   <= sat_q | ovf;
      end
    end
  end

  // The accumulator doubles as the result register, so out_data keeps the
  // last sum after the handshake until the next accepted start clears it.
  assign bus.ap_idle   = (state_q == S_IDLE);
  assign bus.in_ready  = (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.ap_done   = (state_q == S_OUT) && bus.out_ready;
  assign bus.ap_ready  = (state_q == S_OUT) && bus.out_ready;
  assign bus.out_data  = acc_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: tb/tb_case_5_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_case_5_mac_accum
//   Directed bench for case_5_mac_accum. Inputs change 1 ns after a rising
//   edge; outputs are inspected at that point, i.e. away from the edge.
// ---------------------------------------------------------------------------
module tb_case_5_mac_accum;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  case_5_mac_accum_if bus ();

  case_5_mac_accum dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  // Stimulus helpers (no checking inside).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [7:0] l);
    bus.ap_start = 1'b1;
    bus.len      = l;
    step();
    bus.ap_start = 1'b0;
  endtask

  task automatic feed(input logic signed [5:0] a, input logic signed [3:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ap_start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    step(); step();
    total++; if (bus.ap_idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", bus.ap_idle); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 12'sd0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data); else passed++;
    total++; if (bus.ap_done !== 1'b0) $display("FAIL reset_ap_done: got %b want 0", bus.ap_done); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  // (5*3) + (-5*3) + (10*7 = 70 -> low 6 bits = 6) = 6
  task automatic test_basic();
    start_txn(8'd3);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.ap_idle !== 1'b0) $display("FAIL basic_idle: got %b want 0", bus.ap_idle); else passed++;
    feed(6'sd5, 4'sd3);
    feed(-6'sd5, 4'sd3);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); else passed++;
    feed(6'sd10, 4'sd7);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_in_ready_out: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_data !== 12'sd6) $display("FAIL basic_data: got %0d want 6", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL basic_sat: got %b want 0", bus.out_sat); else passed++;
    total++; if (bus.ap_done !== 1'b0) $display("FAIL basic_done_early: got %b want 0", bus.ap_done); else passed++;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.ap_done !== 1'b1) $display("FAIL basic_done: got %b want 1", bus.ap_done); else passed++;
    total++; if (bus.ap_ready !== 1'b1) $display("FAIL basic_ap_ready: got %b want 1", bus.ap_ready); else passed++;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.ap_done !== 1'b0) $display("FAIL basic_done_once: got %b want 0", bus.ap_done); else passed++;
    total++; if (bus.ap_idle !== 1'b1) $display("FAIL basic_back_idle: got %b want 1", bus.ap_idle); else passed++;
    total++; if (bus.out_data !== 12'sd6) $display("FAIL basic_data_held: got %0d want 6", bus.out_data); else passed++;
  endtask

  // 31*7 = 217 -> 25 ; -32*-8 = 256 -> 0
  task automatic test_truncation();
    start_txn(8'd2);
    feed(6'sd31, 4'sd7);
    feed(-6'sd32, -4'sd8);
    total++; if (bus.out_data !== 12'sd25) $display("FAIL trunc_data: got %0d want 25", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL trunc_sat: got %b want 0", bus.out_sat); else passed++;
    handshake();
  endtask

  // 70*31 = 2170 clamps at 2047; 70*-32 = -2240 clamps at -2048.
  // The second run starts in the first idle cycle after the handshake.
  task automatic test_saturation();
    start_txn(8'd70);
    for (int i = 0; i < 70; i++) feed(6'sd31, 4'sd1);
    total++; if (bus.out_data !== 12'sd2047) $display("FAIL sat_pos_data: got %0d want 2047", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b1) $display("FAIL sat_pos_flag: got %b want 1", bus.out_sat); else passed++;
    handshake();
    start_txn(8'd70);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL b2b_sat_cleared: got %b want 0", bus.out_sat); else passed++;
    for (int i = 0; i < 70; i++) feed(-6'sd32, 4'sd1);
    total++; if (bus.out_data !== -12'sd2048) $display("FAIL sat_neg_data: got %0d want -2048", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b1) $display("FAIL sat_neg_flag: got %b want 1", bus.out_sat); else passed++;
    handshake();
  endtask

  // 3*2 + -4*5 + 7*-3 + 1*1 = 6 - 20 - 21 + 1 = -34, with input gaps, a
  // stray ap_start while running and stray in_valid while the result waits.
  task automatic test_backpressure();
    start_txn(8'd4);
    feed(6'sd3, 4'sd2);
    step();
    feed(-6'sd4, 4'sd5);
    bus.ap_start = 1'b1; bus.len = 8'd0;
    step();
    bus.ap_start = 1'b0;
    step();
    feed(6'sd7, -4'sd3);
    feed(6'sd1, 4'sd1);
    bus.in_valid = 1'b1; bus.in_a = 6'sd31; bus.in_b = 4'sd7;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); else passed++;
      total++; if (bus.out_data !== -12'sd34) $display("FAIL bp_data[%0d]: got %0d want -34", i, bus.out_data); else passed++;
      total++; if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0)
        $display("FAIL bp_done[%0d]: got %b%b want 00", i, bus.ap_done, bus.ap_ready); else passed++;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.ap_done !== 1'b1 || bus.ap_ready !== 1'b1)
      $display("FAIL bp_handshake: got %b%b want 11", bus.ap_done, bus.ap_ready); else passed++;
    step();
    bus.out_ready = 1'b0;
    total++; if (bus.ap_done !== 1'b0) $display("FAIL bp_done_after: got %b want 0", bus.ap_done); else passed++;
  endtask

  task automatic test_len_zero();
    start_txn(8'd0);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL len0_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL len0_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_data !== 12'sd0) $display("FAIL len0_data: got %0d want 0", bus.out_data); else passed++;
    handshake();
  endtask

  task automatic test_reset_mid();
    start_txn(8'd4);
    feed(6'sd5, 4'sd5);
    feed(6'sd5, 4'sd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++; if (bus.ap_idle !== 1'b1) $display("FAIL rmid_idle: got %b want 1", bus.ap_idle); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_data !== 12'sd0) $display("FAIL rmid_data: got %0d want 0", bus.out_data); else passed++;
    start_txn(8'd1);
    feed(6'sd2, 4'sd3);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 12'sd6) $display("FAIL rmid_result: got %0d want 6", bus.out_data); else passed++;
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_saturation();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
